// File: rtl/wb_daq_data_mover_if.sv
// Wishbone B3 classic master/slave signal bundle for the DAQ data mover.
interface wb_daq_data_mover_if #(
  parameter int dw = 32,
  parameter int aw = 32
);
  logic [aw-1:0] wbm_adr_o;
  logic [dw-1:0] wbm_dat_o;
  logic [3:0]    wbm_sel_o;
  logic          wbm_we_o;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic [2:0]    wbm_cti_o;
  logic [1:0]    wbm_bte_o;
  logic          wbm_ack_i;
  logic          wbm_err_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
    output wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
    input  wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o,
    output wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/wb_daq_data_mover.sv
// Moves samples from four DAQ channels into per-channel circular buffers in
// system memory using Wishbone single writes, round-robin between channels.
module wb_daq_data_mover #(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int BUF_WORDS = 256
) (
  input  logic                wb_clk,
  input  logic                wb_rst_n,
  input  logic [31:0]         daq_control_reg,
  input  logic [31:0]         daq_channel0_address_reg,
  input  logic [31:0]         daq_channel1_address_reg,
  input  logic [31:0]         daq_channel2_address_reg,
  input  logic [31:0]         daq_channel3_address_reg,
  input  logic [3:0]          ch_valid_i,
  input  logic [4*dw-1:0]     ch_data_i,
  wb_daq_data_mover_if.master wbm,
  output logic [3:0]          wrap_irq,
  output logic [3:0]          overrun,
  output logic [3:0]          bus_err
);
  localparam int OW = $clog2(BUF_WORDS);

  typedef enum logic [1:0] {IDLE, ARB, WRITE, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    cur_ch_q, cur_ch_d;
  logic [1:0]    last_q, last_d;
  logic [aw-1:0] adr_q, adr_d;
  logic [dw-1:0] dat_q, dat_d;
  logic          cyc_q, cyc_d;

  logic [3:0]    active;
  logic [3:0]    hold_full;
  logic [3:0]    consume;
  logic [dw-1:0] hold_data [4];
  logic [OW-1:0] offset [4];
  logic [31:2]   base [4];
  logic          grant_found;
  logic [1:0]    grant_ch;
  logic [31:0]   grant_addr;
  logic          wr_ok;
  logic          wr_fail;
  logic          unused_bits;

  assign base[0] = daq_channel0_address_reg[31:2];
  assign base[1] = daq_channel1_address_reg[31:2];
  assign base[2] = daq_channel2_address_reg[31:2];
  assign base[3] = daq_channel3_address_reg[31:2];

  assign unused_bits = ^{daq_control_reg[31:5],
                         daq_channel0_address_reg[1:0], daq_channel1_address_reg[1:0],
                         daq_channel2_address_reg[1:0], daq_channel3_address_reg[1:0]};

  // ack together with err counts as an error
  assign wr_fail = (state_q == WRITE) && wbm.wbm_err_i;
  assign wr_ok   = (state_q == WRITE) && wbm.wbm_ack_i && !wbm.wbm_err_i;

  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    logic          full_q;
    logic [dw-1:0] data_q;
    logic [OW-1:0] offset_q;
    logic          wrap_q;
    logic          overrun_q;
    logic          bus_err_q;
    logic          mine;

    assign active[gi]  = daq_control_reg[0] & daq_control_reg[gi+1];
    assign consume[gi] = (state_q == ARB) && grant_found && (grant_ch == 2'(gi));
    assign mine        = (state_q == WRITE) && (cur_ch_q == 2'(gi));

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
        full_q <= 1'b0;
        data_q <= '0;
      end else if (!active[gi]) begin
        full_q <= 1'b0;
      end else if (ch_valid_i[gi] && (!full_q || consume[gi])) begin
        full_q <= 1'b1;
        data_q <= ch_data_i[gi*dw +: dw];
      end else if (consume[gi]) begin
        full_q <= 1'b0;
      end
    end

    // An in-flight write finishes against the old offset; the clear lands afterwards.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
        offset_q <= '0;
        wrap_q   <= 1'b0;
      end else begin
        wrap_q <= 1'b0;
        if (mine && wr_ok) begin
          offset_q <= offset_q + OW'(1);
          wrap_q   <= (offset_q == OW'(BUF_WORDS - 1));
        end else if (!active[gi] && !mine) begin
          offset_q <= '0;
        end
      end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
        overrun_q <= 1'b0;
        bus_err_q <= 1'b0;
      end else if (!daq_control_reg[0]) begin
        overrun_q <= 1'b0;
        bus_err_q <= 1'b0;
      end else begin
        if (active[gi] && ch_valid_i[gi] && full_q && !consume[gi]) overrun_q <= 1'b1;
        if (mine && wr_fail) bus_err_q <= 1'b1;
      end
    end

    assign hold_full[gi] = full_q;
    assign hold_data[gi] = data_q;
    assign offset[gi]    = offset_q;
    assign wrap_irq[gi]  = wrap_q;
    assign overrun[gi]   = overrun_q;
    assign bus_err[gi]   = bus_err_q;
  end

  // Search starts one past the last granted channel.
  always_comb begin
    logic [1:0] idx;
    idx         = '0;
    grant_found = 1'b0;
    grant_ch    = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!grant_found && hold_full[idx] && active[idx]) begin
        grant_found = 1'b1;
        grant_ch    = idx;
      end
    end
  end

  assign grant_addr = {base[grant_ch], 2'b00} + (32'(offset[grant_ch]) << 2);

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    last_d   = last_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    cyc_d    = cyc_q;
    case (state_q)
      IDLE: begin
        if (|(hold_full & active)) state_d = ARB;
      end
      ARB: begin
        if (grant_found) begin
          cur_ch_d = grant_ch;
          last_d   = grant_ch;
          adr_d    = aw'(grant_addr);
          dat_d    = hold_data[grant_ch];
          cyc_d    = 1'b1;
          state_d  = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (wbm.wbm_ack_i || wbm.wbm_err_i) begin
          cyc_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= IDLE;
      cur_ch_q <= 2'd0;
      last_q   <= 2'd3;
      adr_q    <= '0;
      dat_q    <= '0;
      cyc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      last_q   <= last_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      cyc_q    <= cyc_d;
    end
  end

  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;
  assign wbm.wbm_sel_o = {4{cyc_q}};
  assign wbm.wbm_we_o  = cyc_q;
  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = cyc_q;
  assign wbm.wbm_cti_o = 3'b000;
  assign wbm.wbm_bte_o = 2'b00;
endmodule

// File: tb/tb_wb_daq_data_mover.sv
// Directed bench for wb_daq_data_mover: a small Wishbone slave with stall and
// error controls, a write monitor, and hand-computed expected writes/flags.
module tb_wb_daq_data_mover;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  ctrl, b0, b1, b2, b3;
  logic [3:0]   valid;
  logic [127:0] data;
  logic [3:0]   wrap_irq, overrun, bus_err;
  logic         stall, err_en;

  always #5 clk = ~clk;

  wb_daq_data_mover_if #(.dw(32), .aw(32)) wbm_if ();

  assign wbm_if.wbm_ack_i = wbm_if.wbm_stb_o & ~stall & ~err_en;
  assign wbm_if.wbm_err_i = wbm_if.wbm_stb_o & err_en;

  wb_daq_data_mover #(.dw(32), .aw(32), .BUF_WORDS(4)) dut (
    .wb_clk                   (clk),
    .wb_rst_n                 (rst_n),
    .daq_control_reg          (ctrl),
    .daq_channel0_address_reg (b0),
    .daq_channel1_address_reg (b1),
    .daq_channel2_address_reg (b2),
    .daq_channel3_address_reg (b3),
    .ch_valid_i               (valid),
    .ch_data_i                (data),
    .wbm                      (wbm_if),
    .wrap_irq                 (wrap_irq),
    .overrun                  (overrun),
    .bus_err                  (bus_err)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        err;
    int          cnt;
  } wr_t;

  wr_t wr_q[$];
  int  cyc_cnt   = 0;
  int  wrap2_n   = 0;
  int  wrap2_cnt = -1;
  int  last_cnt  = 0;
  int  checks    = 0;
  int  errors    = 0;

  // Completed bus transfers, observed mid-cycle
  always @(negedge clk) begin
    wr_t r;
    cyc_cnt++;
    if (wbm_if.wbm_cyc_o && wbm_if.wbm_stb_o && (wbm_if.wbm_ack_i || wbm_if.wbm_err_i)) begin
      r.adr = wbm_if.wbm_adr_o;
      r.dat = wbm_if.wbm_dat_o;
      r.sel = wbm_if.wbm_sel_o;
      r.we  = wbm_if.wbm_we_o;
      r.err = wbm_if.wbm_err_i;
      r.cnt = cyc_cnt;
      wr_q.push_back(r);
    end
    if (wrap_irq[2]) begin
      wrap2_n++;
      wrap2_cnt = cyc_cnt;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] m, input logic [31:0] d0, d1, d2, d3);
    valid = m;
    data  = {d3, d2, d1, d0};
    @(posedge clk);
    #1;
    valid = 4'h0;
  endtask

  task automatic pop_wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic e);
    wr_t r;
    int  t;
    t = 0;
    while (wr_q.size() == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_present"}, 64'(wr_q.size() != 0), 64'd1);
    if (wr_q.size() != 0) begin
      r = wr_q.pop_front();
      check({tag, "_adr"}, r.adr, a);
      check({tag, "_dat"}, r.dat, d);
      check({tag, "_err"}, r.err, e);
      check({tag, "_sel"}, r.sel, 4'hF);
      check({tag, "_we"}, r.we, 1'b1);
      last_cnt = r.cnt;
    end
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; ctrl = '0; b0 = '0; b1 = '0; b2 = '0; b3 = '0;
    valid = '0; data = '0; stall = 1'b0; err_en = 1'b0;
    tick(3);
    @(negedge clk);
    check("rst_cyc", wbm_if.wbm_cyc_o, 1'b0);
    check("rst_stb", wbm_if.wbm_stb_o, 1'b0);
    check("rst_adr", wbm_if.wbm_adr_o, 32'h0);
    check("rst_flags", {wrap_irq, overrun, bus_err}, 12'h000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);

    // All four channels in one cycle: ch0..ch3 order, twice
    b0 = 32'h0; b1 = 32'h400; b2 = 32'h800; b3 = 32'hC00; ctrl = 32'h1F;
    tick(1);
    send(4'hF, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
    tick(20);
    pop_wr("rr1_ch0", 32'h000, 32'hB0, 1'b0);
    c0 = last_cnt;
    pop_wr("rr1_ch1", 32'h400, 32'hB1, 1'b0);
    check("rr1_spacing", 64'(last_cnt - c0), 64'd4);
    pop_wr("rr1_ch2", 32'h800, 32'hB2, 1'b0);
    pop_wr("rr1_ch3", 32'hC00, 32'hB3, 1'b0);
    send(4'hF, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
    tick(20);
    pop_wr("rr2_ch0", 32'h004, 32'hC0, 1'b0);
    pop_wr("rr2_ch1", 32'h404, 32'hC1, 1'b0);
    pop_wr("rr2_ch2", 32'h804, 32'hC2, 1'b0);
    pop_wr("rr2_ch3", 32'hC04, 32'hC3, 1'b0);
    check("rr_overrun", overrun, 4'h0);
    ctrl = 32'h0;
    tick(2);

    // Ch0 alone, three spaced samples, with first-sample latency
    b0 = 32'h1000; ctrl = 32'h3;
    tick(1);
    send(4'h1, 32'hA1, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    check("lat_edge1_stb", wbm_if.wbm_stb_o, 1'b0);
    @(negedge clk);
    check("lat_edge2_stb", wbm_if.wbm_stb_o, 1'b0);
    @(negedge clk);
    check("lat_edge3_stb", wbm_if.wbm_stb_o, 1'b1);
    tick(10);
    send(4'h1, 32'hA2, 32'h0, 32'h0, 32'h0);
    tick(10);
    send(4'h1, 32'hA3, 32'h0, 32'h0, 32'h0);
    tick(10);
    pop_wr("ch0_w0", 32'h1000, 32'hA1, 1'b0);
    pop_wr("ch0_w1", 32'h1004, 32'hA2, 1'b0);
    pop_wr("ch0_w2", 32'h1008, 32'hA3, 1'b0);
    check("ch0_flags", {overrun, bus_err}, 8'h00);
    ctrl = 32'h0;
    tick(2);

    // Ch2 wrap with a 4-word buffer
    b2 = 32'h3000; ctrl = 32'h9;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      send(4'h4, 32'h0, 32'h0, 32'hD0 + 32'(i), 32'h0);
      tick(8);
    end
    pop_wr("wrap_w0", 32'h3000, 32'hD0, 1'b0);
    pop_wr("wrap_w1", 32'h3004, 32'hD1, 1'b0);
    pop_wr("wrap_w2", 32'h3008, 32'hD2, 1'b0);
    pop_wr("wrap_w3", 32'h300C, 32'hD3, 1'b0);
    c0 = last_cnt;
    pop_wr("wrap_w4", 32'h3000, 32'hD4, 1'b0);
    check("wrap_pulses", 64'(wrap2_n), 64'd1);
    check("wrap_timing", 64'(wrap2_cnt), 64'(c0 + 1));
    ctrl = 32'h0;
    tick(2);

    // Ch1 stalled slave: one extra held, next one lost
    b1 = 32'h400; ctrl = 32'h5; stall = 1'b1;
    tick(1);
    send(4'h2, 32'h0, 32'hE0, 32'h0, 32'h0);
    tick(4);
    send(4'h2, 32'h0, 32'hE1, 32'h0, 32'h0);
    tick(3);
    send(4'h2, 32'h0, 32'hE2, 32'h0, 32'h0);
    tick(10);
    @(negedge clk);
    check("stall_stb", wbm_if.wbm_stb_o, 1'b1);
    check("stall_none_done", 64'(wr_q.size()), 64'd0);
    check("stall_overrun", overrun, 4'h2);
    stall = 1'b0;
    tick(20);
    pop_wr("stall_w0", 32'h400, 32'hE0, 1'b0);
    pop_wr("stall_w1", 32'h404, 32'hE1, 1'b0);
    check("stall_no_extra", 64'(wr_q.size()), 64'd0);
    ctrl = 32'h0;
    tick(2);
    check("overrun_clear", overrun, 4'h0);

    // Ch3 bus error keeps the offset
    b3 = 32'h2000; ctrl = 32'h11; err_en = 1'b1;
    tick(1);
    send(4'h8, 32'h0, 32'h0, 32'h0, 32'hF0);
    tick(8);
    pop_wr("err_w0", 32'h2000, 32'hF0, 1'b1);
    check("err_flag", bus_err, 4'h8);
    err_en = 1'b0;
    send(4'h8, 32'h0, 32'h0, 32'h0, 32'hF1);
    tick(8);
    pop_wr("err_w1", 32'h2000, 32'hF1, 1'b0);
    check("err_flag_sticky", bus_err, 4'h8);
    ctrl = 32'h0;
    tick(1);
    @(negedge clk);
    check("err_flag_clear", bus_err, 4'h0);

    // Async reset during a stalled write
    b0 = 32'h1000; ctrl = 32'h3;
    tick(1);
    send(4'h1, 32'h60, 32'h0, 32'h0, 32'h0);
    tick(8);
    pop_wr("rst_pre_w0", 32'h1000, 32'h60, 1'b0);
    stall = 1'b1;
    send(4'h1, 32'h61, 32'h0, 32'h0, 32'h0);
    tick(5);
    send(4'h1, 32'h62, 32'h0, 32'h0, 32'h0);
    tick(2);
    send(4'h1, 32'h63, 32'h0, 32'h0, 32'h0);
    tick(2);
    @(negedge clk);
    check("rst_pre_stb", wbm_if.wbm_stb_o, 1'b1);
    check("rst_pre_adr", wbm_if.wbm_adr_o, 32'h1004);
    check("rst_pre_overrun", overrun, 4'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_cyc", wbm_if.wbm_cyc_o, 1'b0);
    check("rst_async_stb", wbm_if.wbm_stb_o, 1'b0);
    check("rst_async_flags", {wrap_irq, overrun, bus_err}, 12'h000);
    tick(2);
    rst_n = 1'b1;
    stall = 1'b0;
    tick(3);
    check("rst_no_stale", 64'(wr_q.size()), 64'd0);
    send(4'h1, 32'h64, 32'h0, 32'h0, 32'h0);
    tick(8);
    pop_wr("rst_post_w0", 32'h1000, 32'h64, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_daq_data_mover.md
Name: wb_daq_data_mover

Overview:
- Downstream consumer of the DAQ slave register block: takes daq_control_reg and the four channel base-address registers and moves captured samples from four acquisition channels into system memory.
- Acts as a Wishbone B3 classic single-write master.
- Each channel writes into its own circular buffer of BUF_WORDS 32-bit words, starting at that channel's base address.
- Raises per-channel wrap interrupts and overrun/error status flags.

Parameters:
- dw, 32, Wishbone data and sample width.
- aw, 32, Wishbone master address width.
- BUF_WORDS, 256, circular buffer depth per channel in words; must be a power of 2, ≥2.

Ports:
- wb_clk  in  1  system clock.
- wb_rst_n  in  1  reset, asynchronous assert, active-low.
- daq_control_reg  in  32  [0] global enable, [4:1] channel enables ch0..ch3; other bits ignored.
- daq_channel0_address_reg..daq_channel3_address_reg  in  32 each  byte base address per channel; bits [1:0] ignored.
- ch_valid_i  in  4  one-cycle sample strobe per channel.
- ch_data_i  in  4*dw  samples; ch n occupies [n*dw +: dw].
- wbm_adr_o  out  aw  write address.
- wbm_dat_o  out  dw  write data.
- wbm_sel_o  out  4  byte lanes, always 4'hF during a cycle.
- wbm_we_o  out  1  always 1 during a cycle.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_cti_o  out  3  always 3'b000.
- wbm_bte_o  out  2  always 2'b00.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_err_i  in  1  slave error.
- wrap_irq  out  4  one-cycle pulse per channel when its buffer wraps.
- overrun  out  4  sticky; a sample was lost on that channel.
- bus_err  out  4  sticky; a write on that channel got wbm_err_i.

Behaviour:
- Reset (wb_rst_n low, asynchronous): all outputs 0, FSM IDLE, holding registers empty, offsets 0, sticky flags 0. Reset mid-transfer drops cyc/stb immediately with no completion.
- Channel n is active when ctrl[0] & ctrl[n+1].
- Holding register per channel (1 entry):
  - ch_valid_i[n] on an active channel loads the sample and sets full.
  - Inactive channel: the sample is ignored and the holding register is cleared.
  - valid while full and not being consumed this cycle: new sample discarded, old kept, overrun[n] set.
  - valid in the same cycle the entry is consumed (moved to the bus): new sample loaded, no overrun.
- Offset counter per channel, width log2(BUF_WORDS). It resets to 0 whenever the channel is inactive, so a re-enable starts at the base.
- FSM states:
  - IDLE: if any active channel is full, go to ARB next cycle.
  - ARB: round-robin grant, starting at the channel after the last granted one (after reset the first grant starts at ch0). Latch the channel index. Set wbm_adr_o = base + (offset<<2), base[1:0] forced 0, 32-bit wrap-around add. Set wbm_dat_o = held sample. Clear that holding register. Assert cyc/stb/we. Go to WRITE.
  - WRITE: hold all master outputs stable until ack or err.
    - On ack: offset += 1 modulo BUF_WORDS. If offset was BUF_WORDS-1, pulse wrap_irq[n] for one cycle.
    - On err: offset is unchanged, bus_err[n] is set, and the sample is dropped.
    - Deassert cyc/stb the cycle after ack/err is seen; go to IDLE.
    - ack and err together: treated as err.
- Latency: valid at cycle 0 → stb high at cycle 2 when the bus is idle. Minimum of 4 cycles per word with zero-wait ack.
- Disable mid-transfer (enable bit drops while in WRITE): the current write completes normally; afterwards the offset is cleared and no further grants go to that channel.
- Base address change while a channel is active takes effect on the next ARB. Addresses already latched are not altered.
- Sticky flags clear only on reset or when ctrl[0] = 0.

Test Plan:
- Ch0 only enabled (ctrl=0x3), base0=0x1000, 3 samples 0xA1,0xA2,0xA3 spaced 10 cycles, zero-wait ack → writes 0x1000/0xA1, 0x1004/0xA2, 0x1008/0xA3; sel=F, we=1; no flags set.
- All channels enabled (ctrl=0x1F), bases 0x0/0x400/0x800/0xC00; same-cycle valid on all 4 → write order ch0,ch1,ch2,ch3 at offset 0. Repeat → order ch0..ch3 again, each at offset 4.
- BUF_WORDS=4, ch2 enabled, 5 samples → addresses base+0,4,8,C,0; wrap_irq[2] pulses exactly once, in the cycle after the 4th ack.
- Slave stalls ack 20 cycles on ch1; ch1 valid twice more during the stall → first extra sample held, second dropped; overrun[1]=1; the held sample is written after the stall.
- wbm_err_i on first ch3 write, base 0x2000 → bus_err[3]=1; next ch3 sample is written to 0x2000 (offset not advanced).
- wb_rst_n pulled low while stb is high, awaiting ack → cyc/stb/all flags 0 asynchronously. After release, next ch0 sample goes to base0+0.
